cpu_debug_controller: RTL and testbench

//  AXI4-Lite slave that controls and observes one CPU core: reset, run, halt, N-cycle step, PC breakpoint.

---
 rtl/cpu_debug_controller.sv | 238 +++++++++++++++++++++++
 tb/tb_cpu_debug_controller.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_debug_controller.sv
// AXI4-Lite debug controller: core reset/run/halt/step and register observation.
// Define CPU_DBG_BREAKPOINT_EN to add the PC breakpoint (BPADDR/BPCTL).
module cpu_debug_controller #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 16,
  parameter int NUM_REGS = 32,
  parameter int STEP_W = 16
) (
  input  logic s_axi_aclk,
  input  logic s_axi_aresetn,
  output logic CRST,
  output logic CEXEC,
  input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] REGS,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] REGPC,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [2:0] s_axi_awprot,
  input  logic s_axi_awvalid,
  output logic s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic s_axi_wvalid,
  output logic s_axi_wready,
  output logic [1:0] s_axi_bresp,
  output logic s_axi_bvalid,
  input  logic s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [2:0] s_axi_arprot,
  input  logic s_axi_arvalid,
  output logic s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0] s_axi_rresp,
  output logic s_axi_rvalid,
  input  logic s_axi_rready
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int WA = AW - 2;
  localparam int SB = DW / 8;

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_e;

  localparam logic [WA-1:0] A_CTRL   = WA'(0);
  localparam logic [WA-1:0] A_STAT   = WA'(1);
  localparam logic [WA-1:0] A_STEPN  = WA'(2);
  localparam logic [WA-1:0] A_CYC    = WA'(3);
`ifdef CPU_DBG_BREAKPOINT_EN
  localparam logic [WA-1:0] A_BPADDR = WA'(4);
  localparam logic [WA-1:0] A_BPCTL  = WA'(5);
`endif
  localparam int            A_REGS   = 64;
  localparam logic [WA-1:0] A_PC     = WA'(A_REGS + NUM_REGS);

  state_e state_q, state_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic [STEP_W-1:0] stepn_q, stepn_d;
  logic [31:0] cyc_q, cyc_d;
  logic first_q, first_d;
  logic rst_q, rst_d;
  logic awready_q, awready_d;
  logic bvalid_q, bvalid_d;
  logic arready_q, arready_d;
  logic rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [DW-1:0] rmux;

  logic [WA-1:0] wa, ra;
  logic wr, rd, ctl_wr;
  logic cmd_rst, cmd_run, cmd_halt, cmd_step;
  logic bp_stop, bp_hit, exec;

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0] old,
    input logic [DW-1:0] dat,
    input logic [SB-1:0] strb
  );
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SB; b++)
      if (strb[b]) r[b*8 +: 8] = dat[b*8 +: 8];
    return r;
  endfunction

  assign wa = s_axi_awaddr[AW-1:2];
  assign ra = s_axi_araddr[AW-1:2];
  assign wr = awready_q & s_axi_awvalid & s_axi_wvalid;
  assign rd = arready_q & s_axi_arvalid;
  assign ctl_wr = wr & (wa == A_CTRL) & s_axi_wstrb[0];
  assign cmd_rst  = ctl_wr & s_axi_wdata[0];
  assign cmd_run  = ctl_wr & s_axi_wdata[1];
  assign cmd_halt = ctl_wr & s_axi_wdata[2];
  assign cmd_step = ctl_wr & s_axi_wdata[3];

  assign exec = ((state_q == ST_RUN) || (state_q == ST_STEP))
              && !rst_q && !bp_stop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    stepn_d = stepn_q;
    cyc_d   = cyc_q;
    if (state_q == ST_STEP && exec) begin
      if (cnt_q <= STEP_W'(1)) state_d = ST_HALT;
      else cnt_d = cnt_q - STEP_W'(1);
    end
    if (bp_stop || rst_q) state_d = ST_HALT;
    if (cmd_rst || cmd_halt) begin
      state_d = ST_HALT;
    end else if (cmd_step && state_q == ST_HALT) begin
      state_d = ST_STEP;
      cnt_d = (stepn_q == '0) ? STEP_W'(1) : stepn_q;
    end else if (cmd_run && state_q == ST_HALT) begin
      state_d = ST_RUN;
    end
    if (ctl_wr) rst_d = s_axi_wdata[0];
    if (wr && wa == A_STEPN)
      stepn_d = STEP_W'(merge(DW'(stepn_q), s_axi_wdata, s_axi_wstrb));
    if (rst_q) cyc_d = '0;
    else if (exec) cyc_d = cyc_q + 32'd1;
    // breakpoint is masked on the first cycle so execution can resume from it
    first_d = (state_q == ST_HALT) && (state_d != ST_HALT);
  end

  always_comb begin
    awready_d = s_axi_awvalid & s_axi_wvalid & !bvalid_q & !awready_q;
    bvalid_d  = wr | (bvalid_q & !s_axi_bready);
    arready_d = s_axi_arvalid & !rvalid_q & !arready_q;
    rvalid_d  = rd | (rvalid_q & !s_axi_rready);
    rdata_d   = rd ? rmux : rdata_q;
  end

`ifdef CPU_DBG_BREAKPOINT_EN
  logic [DW-1:0] bpaddr_q, bpaddr_d;
  logic bpen_q, bpen_d;
  logic bphit_q, bphit_d;

  always_comb begin
    bpaddr_d = bpaddr_q;
    bpen_d   = bpen_q;
    bphit_d  = bphit_q;
    if (wr && wa == A_BPADDR)
      bpaddr_d = merge(bpaddr_q, s_axi_wdata, s_axi_wstrb);
    if (wr && wa == A_BPCTL && s_axi_wstrb[0]) bpen_d = s_axi_wdata[0];
    if (cmd_run || cmd_step) bphit_d = 1'b0;
    if (bp_stop) bphit_d = 1'b1;
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      bpaddr_q <= '0;
      bpen_q   <= 1'b0;
      bphit_q  <= 1'b0;
    end else begin
      bpaddr_q <= bpaddr_d;
      bpen_q   <= bpen_d;
      bphit_q  <= bphit_d;
    end
  end

  assign bp_stop = bpen_q && (REGPC == bpaddr_q)
                && (state_q != ST_HALT) && !first_q;
  assign bp_hit = bphit_q;
`else
  logic unused_bp;
  assign unused_bp = first_q;
  assign bp_stop = 1'b0;
  assign bp_hit = 1'b0;
`endif

  always_comb begin
    rmux = '0;
    case (ra)
      A_CTRL:   rmux[0] = rst_q;
      A_STAT: begin
        rmux[1:0] = state_q;
        rmux[2]   = bp_hit;
      end
      A_STEPN:  rmux = DW'(stepn_q);
      A_CYC:    rmux = DW'(cyc_q);
`ifdef CPU_DBG_BREAKPOINT_EN
      A_BPADDR: rmux = bpaddr_q;
      A_BPCTL:  rmux[0] = bpen_q;
`endif
      A_PC:     rmux = REGPC;
      default: begin
        for (int i = 0; i < NUM_REGS; i++)
          if (ra == WA'(A_REGS + i)) rmux = REGS[i*DW +: DW];
      end
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q   <= ST_HALT;
      cnt_q     <= '0;
      stepn_q   <= STEP_W'(1);
      cyc_q     <= '0;
      first_q   <= 1'b0;
      rst_q     <= 1'b1;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stepn_q   <= stepn_d;
      cyc_q     <= cyc_d;
      first_q   <= first_d;
      rst_q     <= rst_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                       s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign CRST          = rst_q;
  assign CEXEC         = exec;
  assign s_axi_awready = awready_q;
  assign s_axi_wready  = awready_q;
  assign s_axi_bresp   = 2'b00;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_arready = arready_q;
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = 2'b00;
  assign s_axi_rvalid  = rvalid_q;
endmodule

// File: tb/tb_cpu_debug_controller.sv
// Bench for cpu_debug_controller: random steps/runs/reads vs a transaction model.
// Breakpoint checks run only when CPU_DBG_BREAKPOINT_EN is defined.
module tb_cpu_debug_controller;
  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic crst, cexec;
  logic [15:0] awaddr, araddr;
  logic awvalid, awready, wvalid, wready;
  logic [31:0] wdata, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic bvalid, bready, arvalid, arready, rvalid, rready;

  logic [31:0] regs_m [NR];
  logic [NR*32-1:0] regs_bus;
  always_comb
    for (int i = 0; i < NR; i++) regs_bus[i*32 +: 32] = regs_m[i];

  logic ramp;
  logic [31:0] ramp_pc, fixed_pc, regpc;
  assign regpc = ramp ? ramp_pc : fixed_pc;
  always @(posedge clk)
    ramp_pc <= !ramp ? 32'd0 : (cexec ? ramp_pc + 32'd4 : ramp_pc);

  int exec_cnt = 0;
  always @(negedge clk) if (cexec) exec_cnt <= exec_cnt + 1;

  cpu_debug_controller dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .CRST(crst), .CEXEC(cexec), .REGS(regs_bus), .REGPC(regpc),
    .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arprot(3'b000),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  int total = 0;
  int bad = 0;
  logic hs_exec, hs_crst;
  logic [15:0] stepn_m;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d,
                           input logic [3:0] s);
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) begin
      chk("aw_timeout", 0, 1);
      awvalid = 1'b0; wvalid = 1'b0;
      return;
    end
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    hs_exec = cexec; hs_crst = crst;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) chk("b_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [15:0] a, output logic [31:0] d);
    int n;
    araddr = a; arvalid = 1'b1;
    d = '0;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) begin
      chk("ar_timeout", 0, 1);
      arvalid = 1'b0;
      return;
    end
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (!rvalid) chk("r_timeout", 0, 1);
    d = rdata;
    @(negedge clk);
  endtask

  task automatic set_stepn(input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rv;
    axi_write(16'h008, d, s);
    if (s[0]) stepn_m[7:0] = d[7:0];
    if (s[1]) stepn_m[15:8] = d[15:8];
    axi_read(16'h008, rv);
    chk("stepn_rb", rv, {16'h0, stepn_m});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [31:0] rv, rv2, c0, d;
    logic [3:0] s;
    int e0, k, exp_n, idx, aw_seen, ar_seen, drop, chg;

    awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0;
    araddr = '0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    ramp = 1'b0; fixed_pc = 32'h400; stepn_m = 16'd1;
    hs_exec = 1'b0; hs_crst = 1'b0;
    for (int i = 0; i < NR; i++) regs_m[i] = $urandom;
    regs_m[7] = 32'hDEADBEEF;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_crst", crst, 1);
    chk("rst_cexec", cexec, 0);
    chk("rst_axi", {awready, wready, bvalid, arready, rvalid}, 0);
    chk("rst_rdata", rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    axi_read(16'h004, rv); chk("stat_rst", rv, 0);
    axi_read(16'h008, rv); chk("stepn_rst", rv, 1);
    axi_read(16'h00C, rv); chk("cyc_rst", rv, 0);
    axi_read(16'h000, rv); chk("ctrl_rst", rv, 1);
    axi_write(16'h000, 32'h0, 4'hF);
    chk("crst_clr", crst, 0);
    axi_read(16'h004, rv); chk("stat_halt", rv, 0);

    for (k = 0; k < 8; k++) begin
      if (k == 0) begin d = 32'd5; s = 4'hF; end
      else if (k == 1) begin d = 32'd0; s = 4'hF; end
      else begin
        d = $urandom; d[15:5] = '0;
        s = 4'($urandom_range(0, 15));
      end
      set_stepn(d, s);
      exp_n = (stepn_m == 16'd0) ? 1 : int'(stepn_m);
      axi_read(16'h00C, c0);
      e0 = exec_cnt;
      axi_write(16'h000, 32'h8, 4'h1);
      chk("step_hs", hs_exec, 1);
      repeat (40) @(negedge clk);
      chk("step_len", exec_cnt - e0, exp_n);
      axi_read(16'h004, rv); chk("step_stat", rv, 0);
      axi_read(16'h00C, rv); chk("step_cyc", rv - c0, exp_n);
    end

    axi_write(16'h000, 32'h8, 4'h2);
    chk("nostrb_step", hs_exec, 0);
    axi_write(16'h000, 32'hE, 4'h1);
    chk("prio_halt", hs_exec, 0);
    axi_read(16'h004, rv); chk("prio_stat", rv, 0);
    set_stepn(32'd3, 4'h3);
    e0 = exec_cnt;
    axi_write(16'h000, 32'hA, 4'h1);
    repeat (10) @(negedge clk);
    chk("prio_step", exec_cnt - e0, 3);

    for (k = 0; k < 3; k++) begin
      exp_n = (k == 0) ? 100 : $urandom_range(10, 60);
      axi_read(16'h00C, c0);
      e0 = exec_cnt;
      axi_write(16'h000, 32'h2, 4'h1);
      chk("run_hs", hs_exec, 1);
      axi_write(16'h000, 32'h8, 4'h1);
      axi_read(16'h004, rv); chk("run_stat", rv, 1);
      repeat (exp_n) @(negedge clk);
      axi_write(16'h000, 32'h4, 4'h1);
      chk("halt_hs", hs_exec, 0);
      axi_read(16'h004, rv); chk("halt_stat", rv, 0);
      axi_read(16'h00C, rv); chk("run_cyc", rv - c0, exec_cnt - e0);
      chk("run_len", (exec_cnt - e0) >= exp_n + 6, 1);
    end

    for (k = 0; k < 10; k++) begin
      idx = (k == 0) ? 7 : $urandom_range(0, NR - 1);
      axi_read(16'(16'h100 + 4 * idx), rv);
      chk("regs_rd", rv, regs_m[idx]);
    end
    axi_read(16'(16'h100 + 4 * NR), rv); chk("pc_rd", rv, 32'h400);
    fixed_pc = $urandom;
    axi_read(16'(16'h100 + 4 * NR), rv); chk("pc_rd2", rv, fixed_pc);
    axi_read(16'h7F0, rv); chk("unmapped", rv, 0);

`ifdef CPU_DBG_BREAKPOINT_EN
    ramp = 1'b1;
    axi_write(16'h010, 32'h40, 4'hF);
    axi_write(16'h014, 32'h1, 4'hF);
    axi_read(16'h010, rv); chk("bpaddr_rb", rv, 32'h40);
    axi_read(16'h014, rv); chk("bpctl_rb", rv, 1);
    axi_write(16'h000, 32'h2, 4'h1);
    repeat (40) @(negedge clk);
    chk("bp_pc", regpc, 32'h40);
    chk("bp_cexec", cexec, 0);
    axi_read(16'h004, rv); chk("bp_stat", rv, 32'h4);
    axi_write(16'h000, 32'h2, 4'h1);
    chk("bp_resume", hs_exec, 1);
    repeat (5) @(negedge clk);
    chk("bp_past", regpc > 32'h40, 1);
    axi_read(16'h004, rv); chk("bp_stat2", rv, 1);
    axi_write(16'h000, 32'h4, 4'h1);
    axi_write(16'h014, 32'h0, 4'hF);
    ramp = 1'b0;
`else
    axi_read(16'h010, rv); chk("bpaddr_off", rv, 0);
    axi_read(16'h014, rv); chk("bpctl_off", rv, 0);
`endif

    bready = 1'b0;
    awaddr = 16'h008; wdata = 32'd7; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    k = 0;
    while (!awready && k < 50) begin @(negedge clk); k++; end
    chk("bp1_aw", awready, 1);
    @(negedge clk);
    wdata = 32'd9;
    aw_seen = 0; drop = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (awready) aw_seen++;
      if (!bvalid) drop++;
    end
    chk("bp_no_aw", aw_seen, 0);
    chk("bp_bhold", drop, 0);
    bready = 1'b1;
    k = 0;
    while (!awready && k < 50) begin @(negedge clk); k++; end
    chk("bp2_aw", awready, 1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (3) @(negedge clk);
    stepn_m = 16'd9;

    rready = 1'b0;
    araddr = 16'h008; arvalid = 1'b1;
    k = 0;
    while (!arready && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    araddr = 16'h00C;
    rv = rdata;
    ar_seen = 0; drop = 0; chg = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (arready) ar_seen++;
      if (!rvalid) drop++;
      if (rdata !== rv) chg++;
    end
    chk("rp_no_ar", ar_seen, 0);
    chk("rp_rhold", drop, 0);
    chk("rp_stable", chg, 0);
    chk("rp_data", rv, 9);
    rready = 1'b1;
    k = 0;
    while (!arready && k < 50) begin @(negedge clk); k++; end
    @(negedge clk);
    arvalid = 1'b0;
    repeat (3) @(negedge clk);

    set_stepn(32'd50, 4'h3);
    axi_write(16'h000, 32'h8, 4'h1);
    repeat (3) @(negedge clk);
    chk("mid_exec", cexec, 1);
    axi_write(16'h000, 32'h1, 4'h1);
    chk("wrst_exec", hs_exec, 0);
    chk("wrst_crst", hs_crst, 1);
    axi_read(16'h00C, rv); chk("wrst_cyc", rv, 0);
    axi_read(16'h004, rv); chk("wrst_stat", rv, 0);
    axi_write(16'h000, 32'h0, 4'h1);
    axi_write(16'h000, 32'h8, 4'h1);
    repeat (3) @(negedge clk);
    chk("mid_exec2", cexec, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_exec", cexec, 0);
    chk("arst_crst", crst, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    axi_read(16'h008, rv2); chk("arst_stepn", rv2, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
